// File: rtl/pipeline_stall_control.sv
// Pipeline interlock controller: freezes stages, inserts bubbles and flushes wrong-path
// instructions for load-use, taken branches, multi-cycle EX ops and data-memory wait states.
module pipeline_stall_control #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       d_rs1,
  input  logic [4:0]       d_rs2,
  input  logic             d_uses_rs1,
  input  logic             d_uses_rs2,
  input  logic             e_mem_read,
  input  logic             e_reg_write_enable,
  input  logic [4:0]       e_dest_reg,
  input  logic             e_branch_taken,
  input  logic             e_mc_start,
  input  logic             mc_done,
  input  logic             m_mem_req,
  input  logic             m_mem_ready,
  output logic             pc_enable,
  output logic             f_d_enable,
  output logic             d_e_enable,
  output logic             e_m_enable,
  output logic             m_w_enable,
  output logic             f_d_flush,
  output logic             d_e_flush,
  output logic             e_m_flush,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StMcWait  = 2'd1,
    StMemWait = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             mc_done_pending_q, mc_done_pending_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;

  logic mem_freeze;
  logic mc_busy;
  logic rs1_hit;
  logic rs2_hit;
  logic load_use;

  // x0 is hard-wired zero, so a load targeting it never creates a dependency.
  assign rs1_hit  = d_uses_rs1 && (d_rs1 == e_dest_reg);
  assign rs2_hit  = d_uses_rs2 && (d_rs2 == e_dest_reg);
  assign load_use = e_mem_read && e_reg_write_enable && (e_dest_reg != 5'd0) &&
                    (rs1_hit || rs2_hit);

  always_comb begin
    mem_freeze = 1'b0;
    mc_busy    = 1'b0;
    unique case (state_q)
      StRun: begin
        mem_freeze = m_mem_req && !m_mem_ready;
        mc_busy    = e_mc_start && !mc_done;
      end
      StMcWait: begin
        mem_freeze = m_mem_req && !m_mem_ready;
        mc_busy    = !mc_done && !mc_done_pending_q;
      end
      StMemWait: begin
        mem_freeze = !m_mem_ready;
      end
      default: ;
    endcase
  end

  always_comb begin
    pc_enable         = 1'b1;
    f_d_enable        = 1'b1;
    d_e_enable        = 1'b1;
    e_m_enable        = 1'b1;
    m_w_enable        = 1'b1;
    f_d_flush         = 1'b0;
    d_e_flush         = 1'b0;
    e_m_flush         = 1'b0;
    state_d           = state_q;
    mc_done_pending_d = mc_done_pending_q;

    if (!reset) begin
      pc_enable  = 1'b0;
      f_d_enable = 1'b0;
      d_e_enable = 1'b0;
      e_m_enable = 1'b0;
      m_w_enable = 1'b0;
      f_d_flush  = 1'b1;
      d_e_flush  = 1'b1;
      e_m_flush  = 1'b1;
    end else if (mem_freeze) begin
      pc_enable  = 1'b0;
      f_d_enable = 1'b0;
      d_e_enable = 1'b0;
      e_m_enable = 1'b0;
      m_w_enable = 1'b0;
      if (state_q == StRun) begin
        state_d = StMemWait;
      end else if (state_q == StMcWait && mc_done) begin
        // EX is frozen, so remember the result pulse until MEM releases.
        mc_done_pending_d = 1'b1;
      end
    end else if (state_q == StMemWait) begin
      state_d = StRun;
    end else if (mc_busy) begin
      pc_enable  = 1'b0;
      f_d_enable = 1'b0;
      d_e_enable = 1'b0;
      e_m_flush  = 1'b1;
      state_d    = StMcWait;
    end else if (state_q == StMcWait) begin
      mc_done_pending_d = 1'b0;
      state_d           = StRun;
    end else if (e_branch_taken) begin
      // The decode instruction is on the wrong path, so any load-use match is moot.
      f_d_flush = 1'b1;
      d_e_flush = 1'b1;
    end else if (load_use) begin
      pc_enable  = 1'b0;
      f_d_enable = 1'b0;
      d_e_flush  = 1'b1;
    end
  end

  always_comb begin
    stall_count_d = stall_count_q;
    if (!pc_enable && (stall_count_q != {CNT_W{1'b1}})) begin
      stall_count_d = stall_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q           <= StRun;
      mc_done_pending_q <= 1'b0;
      stall_count_q     <= '0;
    end else begin
      state_q           <= state_d;
      mc_done_pending_q <= mc_done_pending_d;
      stall_count_q     <= stall_count_d;
    end
  end

  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_pipeline_stall_control.sv
// Bench for pipeline_stall_control: directed vector table, hand sequences for reset and
// multi-cycle stalls, then random traffic checked against a behavioural model.
module tb_pipeline_stall_control;

  typedef struct {
    logic [4:0] rs1, rs2;
    logic       u1, u2, mr, rw;
    logic [4:0] dest;
    logic       br, mcs, mcd, req, rdy;
  } in_t;

  typedef struct {
    in_t        i;
    logic [4:0] en;   // {pc, f_d, d_e, e_m, m_w}
    logic [2:0] fl;   // {f_d, d_e, e_m}
    int         cnt;  // stall_count after the edge
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [4:0]  d_rs1, d_rs2, e_dest_reg;
  logic        d_uses_rs1, d_uses_rs2, e_mem_read, e_reg_write_enable;
  logic        e_branch_taken, e_mc_start, mc_done, m_mem_req, m_mem_ready;
  logic        pc_enable, f_d_enable, d_e_enable, e_m_enable, m_w_enable;
  logic        f_d_flush, d_e_flush, e_m_flush;
  logic [31:0] stall_count;
  logic        s_pc, s_fd, s_de, s_em, s_mw, s_ffd, s_fde, s_fem;
  logic [2:0]  stall_count_s;

  int total = 0;
  int bad = 0;

  // Model state: which wait the pipeline is in, a banked mc_done, and the stall tally.
  bit     mdl_in_mem_wait;
  bit     mdl_in_mc_wait;
  bit     mdl_done_banked;
  longint mdl_cnt;

  vec_t tbl[25];

  always #5 clk = ~clk;

  pipeline_stall_control #(.CNT_W(32)) dut (
    .clk(clk), .reset(reset), .d_rs1(d_rs1), .d_rs2(d_rs2), .d_uses_rs1(d_uses_rs1),
    .d_uses_rs2(d_uses_rs2), .e_mem_read(e_mem_read), .e_reg_write_enable(e_reg_write_enable),
    .e_dest_reg(e_dest_reg), .e_branch_taken(e_branch_taken), .e_mc_start(e_mc_start),
    .mc_done(mc_done), .m_mem_req(m_mem_req), .m_mem_ready(m_mem_ready),
    .pc_enable(pc_enable), .f_d_enable(f_d_enable), .d_e_enable(d_e_enable),
    .e_m_enable(e_m_enable), .m_w_enable(m_w_enable), .f_d_flush(f_d_flush),
    .d_e_flush(d_e_flush), .e_m_flush(e_m_flush), .stall_count(stall_count)
  );

  // Narrow counter instance to exercise saturation.
  pipeline_stall_control #(.CNT_W(3)) dut_sat (
    .clk(clk), .reset(reset), .d_rs1(d_rs1), .d_rs2(d_rs2), .d_uses_rs1(d_uses_rs1),
    .d_uses_rs2(d_uses_rs2), .e_mem_read(e_mem_read), .e_reg_write_enable(e_reg_write_enable),
    .e_dest_reg(e_dest_reg), .e_branch_taken(e_branch_taken), .e_mc_start(e_mc_start),
    .mc_done(mc_done), .m_mem_req(m_mem_req), .m_mem_ready(m_mem_ready),
    .pc_enable(s_pc), .f_d_enable(s_fd), .d_e_enable(s_de), .e_m_enable(s_em),
    .m_w_enable(s_mw), .f_d_flush(s_ffd), .d_e_flush(s_fde), .e_m_flush(s_fem),
    .stall_count(stall_count_s)
  );

  function automatic in_t mk(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                             input logic u2, input logic mr, input logic rw,
                             input logic [4:0] dest, input logic br, input logic mcs,
                             input logic mcd, input logic req, input logic rdy);
    in_t v;
    v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2; v.mr = mr; v.rw = rw;
    v.dest = dest; v.br = br; v.mcs = mcs; v.mcd = mcd; v.req = req; v.rdy = rdy;
    return v;
  endfunction

  function automatic vec_t vec(input in_t i, input logic [4:0] en, input logic [2:0] fl,
                               input int cnt);
    vec_t r;
    r.i = i; r.en = en; r.fl = fl; r.cnt = cnt;
    return r;
  endfunction

  task automatic apply(input in_t v);
    d_rs1 = v.rs1; d_rs2 = v.rs2; d_uses_rs1 = v.u1; d_uses_rs2 = v.u2;
    e_mem_read = v.mr; e_reg_write_enable = v.rw; e_dest_reg = v.dest;
    e_branch_taken = v.br; e_mc_start = v.mcs; mc_done = v.mcd;
    m_mem_req = v.req; m_mem_ready = v.rdy;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] en_vec();
    return {pc_enable, f_d_enable, d_e_enable, e_m_enable, m_w_enable};
  endfunction

  function automatic logic [2:0] fl_vec();
    return {f_d_flush, d_e_flush, e_m_flush};
  endfunction

  function automatic longint sat7(input longint c);
    return (c > 7) ? 7 : c;
  endfunction

  task automatic model_reset();
    mdl_in_mem_wait = 0; mdl_in_mc_wait = 0; mdl_done_banked = 0; mdl_cnt = 0;
  endtask

  // Reference: what the pipeline should do this cycle, and how the model state moves on.
  task automatic model_step(input in_t v, input bit commit,
                            output logic [4:0] en, output logic [2:0] fl);
    bit running, frozen, mc_hold, hazard, lu, kill;
    running = !mdl_in_mem_wait && !mdl_in_mc_wait;
    frozen  = mdl_in_mem_wait ? !v.rdy : (v.req && !v.rdy);
    mc_hold = !frozen && !mdl_in_mem_wait &&
              (mdl_in_mc_wait ? !(v.mcd || mdl_done_banked) : (v.mcs && !v.mcd));
    hazard  = v.mr && v.rw && v.dest != 0 &&
              ((v.u1 && v.rs1 == v.dest) || (v.u2 && v.rs2 == v.dest));
    kill    = running && !frozen && !mc_hold && v.br;
    lu      = running && !frozen && !mc_hold && !v.br && hazard;
    en = {!(frozen || mc_hold || lu), !(frozen || mc_hold || lu), !(frozen || mc_hold),
          !frozen, !frozen};
    fl = {kill, kill || lu, mc_hold};
    if (commit) begin
      if (en[4] == 1'b0) mdl_cnt++;
      if (frozen) begin
        if (running) mdl_in_mem_wait = 1;
        else if (mdl_in_mc_wait && v.mcd) mdl_done_banked = 1;
      end else if (mdl_in_mem_wait) begin
        mdl_in_mem_wait = 0;
      end else if (mc_hold) begin
        mdl_in_mc_wait = 1;
      end else if (mdl_in_mc_wait) begin
        mdl_in_mc_wait = 0;
        mdl_done_banked = 0;
      end
    end
  endtask

  function automatic in_t rand_in();
    in_t v;
    v.rs1 = 5'($urandom_range(0, 3)); v.rs2 = 5'($urandom_range(0, 3));
    v.dest = 5'($urandom_range(0, 3));
    v.u1 = 1'($urandom); v.u2 = 1'($urandom);
    v.mr = ($urandom_range(0, 99) < 50); v.rw = ($urandom_range(0, 99) < 80);
    v.mcs = ($urandom_range(0, 99) < 20);
    v.br = !v.mcs && ($urandom_range(0, 99) < 15);
    v.mcd = ($urandom_range(0, 99) < 25);
    v.req = ($urandom_range(0, 99) < 30); v.rdy = ($urandom_range(0, 99) < 50);
    return v;
  endfunction

  initial begin
    in_t        idle, v;
    logic [4:0] een;
    logic [2:0] efl;
    longint     c0;

    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    //                rs1 rs2 u1 u2 mr rw dst br mcs mcd req rdy
    tbl[0]  = vec(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 5'b11111, 3'b000, 0);
    tbl[1]  = vec(mk(0, 5, 0, 1, 1, 1, 5, 0, 0, 0, 0, 0), 5'b00111, 3'b010, 1);
    tbl[2]  = vec(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 5'b11111, 3'b000, 1);
    tbl[3]  = vec(mk(0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0), 5'b11111, 3'b000, 1);
    tbl[4]  = vec(mk(0, 5, 0, 1, 1, 1, 5, 1, 0, 0, 0, 0), 5'b11111, 3'b110, 1);
    tbl[5]  = vec(mk(7, 0, 0, 0, 1, 1, 7, 0, 0, 0, 0, 0), 5'b11111, 3'b000, 1);
    tbl[6]  = vec(mk(7, 0, 1, 0, 1, 0, 7, 0, 0, 0, 0, 0), 5'b11111, 3'b000, 1);
    tbl[7]  = vec(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0), 5'b00011, 3'b001, 2);
    tbl[8]  = vec(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0), 5'b00011, 3'b001, 3);
    tbl[9]  = vec(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0), 5'b11111, 3'b000, 3);
    tbl[10] = vec(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0), 5'b11111, 3'b000, 3);
    tbl[11] = vec(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), 5'b00000, 3'b000, 4);
    tbl[12] = vec(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), 5'b00000, 3'b000, 5);
    tbl[13] = vec(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1), 5'b11111, 3'b000, 5);
    tbl[14] = vec(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1), 5'b11111, 3'b000, 5);
    tbl[15] = vec(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0), 5'b00011, 3'b001, 6);
    tbl[16] = vec(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0), 5'b00000, 3'b000, 7);
    tbl[17] = vec(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0), 5'b00000, 3'b000, 8);
    tbl[18] = vec(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1), 5'b11111, 3'b000, 8);
    tbl[19] = vec(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0), 5'b00011, 3'b001, 9);
    tbl[20] = vec(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0), 5'b00011, 3'b001, 10);
    tbl[21] = vec(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0), 5'b11111, 3'b000, 10);
    tbl[22] = vec(mk(3, 0, 1, 0, 1, 1, 3, 0, 0, 0, 0, 0), 5'b00111, 3'b010, 11);
    tbl[23] = vec(mk(3, 0, 1, 0, 1, 1, 3, 0, 0, 0, 1, 0), 5'b00000, 3'b000, 12);
    tbl[24] = vec(mk(3, 0, 1, 0, 1, 1, 3, 0, 0, 0, 1, 1), 5'b11111, 3'b000, 12);

    // Reset held low for three cycles.
    apply(idle);
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      chk("rst_en", 64'(en_vec()), 64'(5'b00000));
      chk("rst_fl", 64'(fl_vec()), 64'(3'b111));
      chk("rst_cnt", 64'(stall_count), 64'd0);
    end
    @(negedge clk);
    reset = 1'b1;

    foreach (tbl[k]) begin
      if (k != 0) @(negedge clk);
      apply(tbl[k].i);
      #1;
      chk($sformatf("vec%0d_en", k), 64'(en_vec()), 64'(tbl[k].en));
      chk($sformatf("vec%0d_fl", k), 64'(fl_vec()), 64'(tbl[k].fl));
      @(posedge clk); #1;
      chk($sformatf("vec%0d_cnt", k), 64'(stall_count), 64'(tbl[k].cnt));
    end
    chk("sat_cnt", 64'(stall_count_s), 64'd7);

    // Multi-cycle op: start at t, done at t+4 gives four stall cycles.
    c0 = longint'(stall_count);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      v = idle; v.mcs = 1'b1; v.mcd = (c == 4);
      apply(v);
      #1;
      chk($sformatf("mc_pc_c%0d", c), 64'(pc_enable), (c == 4) ? 64'd1 : 64'd0);
      chk($sformatf("mc_emfl_c%0d", c), 64'(e_m_flush), (c == 4) ? 64'd0 : 64'd1);
    end
    @(posedge clk); #1;
    chk("mc_cnt_delta", 64'(longint'(stall_count) - c0), 64'd4);

    // Reset in the middle of a multi-cycle stall.
    @(negedge clk);
    v = idle; v.mcs = 1'b1;
    apply(v);
    @(negedge clk);
    apply(idle);
    reset = 1'b0;
    #1;
    chk("midrst_en", 64'(en_vec()), 64'(5'b00000));
    chk("midrst_fl", 64'(fl_vec()), 64'(3'b111));
    chk("midrst_cnt", 64'(stall_count), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst_run", 64'(en_vec()), 64'(5'b11111));
    @(posedge clk); #1;
    chk("midrst_cnt2", 64'(stall_count), 64'd0);

    // Random traffic against the model, with occasional resets.
    model_reset();
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if ($urandom_range(0, 199) == 0) begin
        apply(idle);
        reset = 1'b0;
        #1;
        chk("rnd_rst_en", 64'(en_vec()), 64'(5'b00000));
        chk("rnd_rst_cnt", 64'(stall_count), 64'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
      end else begin
        v = rand_in();
        apply(v);
        #1;
        model_step(v, 1'b0, een, efl);
        chk("rnd_en", 64'(en_vec()), 64'(een));
        chk("rnd_fl", 64'(fl_vec()), 64'(efl));
        @(posedge clk);
        model_step(v, 1'b1, een, efl);
        #1;
        chk("rnd_cnt", 64'(stall_count), 64'(mdl_cnt));
        chk("rnd_sat", 64'(stall_count_s), 64'(sat7(mdl_cnt)));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipeline_stall_control.md
# pipeline_stall_control

Pipeline interlock controller for the five-stage core, complementing the operand-forwarding unit. Forwarding resolves hazards by bypassing data. This block resolves the hazards that bypassing cannot: it freezes stages, inserts bubbles and flushes wrong-path instructions. Scope:
- load-use hazards
- taken branches resolved in EX
- multi-cycle EX operations (mul/div) with a start/done handshake
- data-memory wait states in MEM

It drives the enable and flush pins of the PC and all pipeline registers, and keeps a stall-cycle counter for performance analysis.

## Interface
Parameters:
- CNT_W, 32, width of the stall counter

Ports:
- clk  in  1  core clock, rising edge
- reset  in  1  asynchronous, active-low; low = in reset
- d_rs1, d_rs2  in  5  source registers of the instruction in decode
- d_uses_rs1, d_uses_rs2  in  1  decode instruction actually reads rs1 / rs2
- e_mem_read  in  1  EX instruction is a load
- e_reg_write_enable  in  1  EX instruction writes a register
- e_dest_reg  in  5  EX destination register
- e_branch_taken  in  1  EX resolved a taken branch or jump this cycle
- e_mc_start  in  1  EX holds a multi-cycle op issuing this cycle
- mc_done  in  1  single-cycle pulse: multi-cycle result valid
- m_mem_req  in  1  MEM instruction accesses data memory
- m_mem_ready  in  1  data memory completes the access this cycle
- pc_enable, f_d_enable, d_e_enable, e_m_enable, m_w_enable  out  1 each  register load enables
- f_d_flush, d_e_flush, e_m_flush  out  1 each  load a bubble (NOP) instead of data
- stall_count  out  CNT_W  cycles with pc_enable = 0

## Operation
States:
- RUN
- MC_WAIT: a multi-cycle op is in EX
- MEM_WAIT: the data access in MEM is pending

Internal flag mc_done_pending latches an mc_done pulse that arrives while MEM is frozen.

Actions are evaluated in priority order. Every enable defaults to 1 and every flush to 0.

1. **Mem freeze.** Condition: (m_mem_req && !m_mem_ready) in RUN or MC_WAIT, or (MEM_WAIT && !m_mem_ready).
   - All five enables 0, all flushes 0.
   - From RUN, go to MEM_WAIT.
   - In MC_WAIT, stay in MC_WAIT; an mc_done arriving during the freeze sets mc_done_pending.
2. **MEM_WAIT && m_mem_ready.** All enables 1; go to RUN.
3. **MC busy.** Condition: (RUN && e_mc_start && !mc_done), or (MC_WAIT && !mc_done && !mc_done_pending).
   - pc_enable, f_d_enable, d_e_enable = 0; e_m_flush = 1.
   - From RUN, go to MC_WAIT.
4. **MC_WAIT with mc_done or mc_done_pending.** All enables 1, e_m_flush 0; clear mc_done_pending; go to RUN.
5. **Branch (RUN only).** Condition: e_branch_taken. f_d_flush = 1, d_e_flush = 1.
6. **Load-use (RUN only).** Condition: e_mem_read && e_reg_write_enable && e_dest_reg != 0 && ((d_uses_rs1 && d_rs1 == e_dest_reg) || (d_uses_rs2 && d_rs2 == e_dest_reg)).
   - pc_enable = 0, f_d_enable = 0, d_e_flush = 1.
7. **Otherwise.** All advance.

Further rules:
- Branch outranks load-use because the decode instruction is killed. e_branch_taken with e_mc_start is illegal.
- Register x0 never causes a load-use stall.
- stall_count increments on every clock with pc_enable = 0 and saturates at all-ones, with no wrap.

## Timing
- Outputs are combinational from state and inputs. State, mc_done_pending and stall_count update on the rising edge of clk.
- While reset is low:
  - all enables 0, all flushes 1
  - state RUN, mc_done_pending 0, stall_count 0
- Reset low mid-stall aborts immediately. First cycle after release: state RUN.
- Load-use penalty: exactly 1 bubble. The second cycle proceeds because the load has moved to MEM.
- Taken-branch penalty: 2 bubbles, F/D and D/E flushed in the same cycle.
- Multi-cycle op, start at cycle t, mc_done at cycle t+k: stall cycles t .. t+k-1, advance at t+k.
- e_mc_start and mc_done in the same cycle: zero stall.
- Mem wait with m_mem_ready asserted n cycles after request: n freeze cycles, advance on the ready cycle.
- mc_done during a mem freeze inside MC_WAIT: on the cycle the freeze ends, the pipeline advances directly (rule 4). No extra cycle.

## Test plan
- **Reset:** hold reset low 3 cycles.
  - All enables 0, flushes 1, stall_count 0.
  - After release with idle inputs, all enables 1 and flushes 0.
- **Load-use:** e_mem_read = 1, e_dest_reg = 5, d_rs2 = 5, d_uses_rs2 = 1.
  - One cycle of pc_enable = 0, f_d_enable = 0, d_e_flush = 1; stall_count becomes 1.
  - Repeat with e_dest_reg = 0: no stall.
- **Branch with simultaneous load-use:** e_branch_taken = 1 together with the load-use match.
  - f_d_flush = d_e_flush = 1, pc_enable = 1, stall_count unchanged.
- **Multi-cycle:** e_mc_start at cycle 10, mc_done at cycle 14.
  - Stall cycles 10-13 with e_m_flush = 1; advance at 14; stall_count = 4.
  - Start and done in the same cycle: no stall.
- **Mem wait:** m_mem_req = 1 with m_mem_ready low for 3 cycles.
  - All enables 0 for 3 cycles, then all 1 on the ready cycle; state returns to RUN.
- **Nested mem freeze in MC_WAIT:** mc_done pulses during the freeze.
  - The pipeline advances on the m_mem_ready cycle.
  - No hang in MC_WAIT.
  - mc_done_pending is cleared afterwards.
